// File: rtl/frame_compositor.sv
// Frame compositor: merges the game layer, background colour and the
// game-over overlay into the final RGB stream with a fixed 2-cycle latency.
// Timing signals (hsync/vsync/de) are delayed by the same 2 stages.
// Optional feature macro: GAMEOVER_BLINK_EN (blinks the game-over text
// with a half-period of BLINK_FRAMES frames).
module frame_compositor #(
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic            pixel_clk,
    input  logic            rst,
    input  logic            fsync,
    input  logic            hsync_in,
    input  logic            vsync_in,
    input  logic            de_in,
    input  logic [2:0][7:0] pixel_game,
    input  logic            active_game,
    input  logic            use_gameover_pixels,
    input  logic [2:0][7:0] pixel_gameover,
    output logic            hsync_out,
    output logic            vsync_out,
    output logic            de_out,
    output logic [2:0][7:0] pixel_out,
    output logic            overlay_active
);

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
        $error("frame_compositor: BLINK_FRAMES must be in 1..255");
    end

    // Stage 1 registers
    logic            hs_s1_q, vs_s1_q, de_s1_q;
    logic            act_s1_q, transp_s1_q;
    logic [2:0][7:0] game_s1_q, go_s1_q;

    // Stage 2 / output registers
    logic            hs_s2_q, vs_s2_q, de_s2_q;
    logic [2:0][7:0] pixel_q, pixel_d;

    // Frame-stable overlay flag
    logic            overlay_q;

    // Text visibility as seen at stage-2 time
    logic            text_vis;

    logic [2:0][7:0] base_c, dim_c;

    // Stage 1: capture raw inputs and the transparency test
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            de_s1_q     <= 1'b0;
            act_s1_q    <= 1'b0;
            transp_s1_q <= 1'b0;
            game_s1_q   <= '0;
            go_s1_q     <= '0;
        end else begin
            hs_s1_q     <= hsync_in;
            vs_s1_q     <= vsync_in;
            de_s1_q     <= de_in;
            act_s1_q    <= active_game;
            transp_s1_q <= (pixel_gameover == '0);
            game_s1_q   <= pixel_game;
            go_s1_q     <= pixel_gameover;
        end
    end

    // Overlay flag only changes at frame start so a frame is never mixed
    always_ff @(posedge pixel_clk) begin
        if (rst)        overlay_q <= 1'b0;
        else if (fsync) overlay_q <= use_gameover_pixels;
    end

`ifdef GAMEOVER_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    // Blink counter: held clear while the overlay is off so each overlay
    // starts in the visible phase; steps once per frame otherwise
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!overlay_q) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (fsync) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    // Blink state register
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign text_vis = ~blink_ph_q;
`else
    assign text_vis = 1'b1;
`endif

    // Colour select: blanking, overlay text, dimmed base, plain base
    always_comb begin
        base_c  = act_s1_q ? game_s1_q : BG_COLOR;
        dim_c   = '0;
        for (int ch = 0; ch < 3; ch++) begin
            dim_c[ch] = base_c[ch] >> 2;
        end
        pixel_d = '0;
        if (!de_s1_q)                                  pixel_d = '0;
        else if (overlay_q && text_vis && !transp_s1_q) pixel_d = go_s1_q;
        else if (overlay_q)                            pixel_d = dim_c;
        else                                           pixel_d = base_c;
    end

    // Stage 2: register final colour and delayed timing
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hs_s2_q <= 1'b0;
            vs_s2_q <= 1'b0;
            de_s2_q <= 1'b0;
            pixel_q <= '0;
        end else begin
            hs_s2_q <= hs_s1_q;
            vs_s2_q <= vs_s1_q;
            de_s2_q <= de_s1_q;
            pixel_q <= pixel_d;
        end
    end

    assign hsync_out      = hs_s2_q;
    assign vsync_out      = vs_s2_q;
    assign de_out         = de_s2_q;
    assign pixel_out      = pixel_q;
    assign overlay_active = overlay_q;

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor: table of steady-state colour-select
// vectors plus hand-written sequences for latency, overlay framing, reset
// and (when GAMEOVER_BLINK_EN is defined) blinking.
module tb_frame_compositor;

`ifdef GAMEOVER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic            pixel_clk = 1'b0;
    logic            rst, fsync, hsync_in, vsync_in, de_in;
    logic [2:0][7:0] pixel_game, pixel_gameover;
    logic            active_game, use_gameover_pixels;
    logic            hsync_out, vsync_out, de_out, overlay_active;
    logic [2:0][7:0] pixel_out;

    int n_chk  = 0;
    int n_fail = 0;

    frame_compositor #(.BG_COLOR(24'h102030), .BLINK_FRAMES(2)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .pixel_game(pixel_game), .active_game(active_game),
        .use_gameover_pixels(use_gameover_pixels), .pixel_gameover(pixel_gameover),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .pixel_out(pixel_out), .overlay_active(overlay_active)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic        ov, de, act, hs, vs;
        logic [23:0] game, go, exp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One frame: fsync pulse then (len-1) more cycles
    task automatic frame(input logic use_ov, input int len);
        fsync = 1'b1;
        use_gameover_pixels = use_ov;
        tick();
        fsync = 1'b0;
        repeat (len - 1) tick();
    endtask

    task automatic set_pix(input logic de, input logic act, input logic [23:0] game,
                           input logic [23:0] go);
        de_in = de;
        active_game = act;
        pixel_game = game;
        pixel_gameover = go;
    endtask

    logic [2:0] prev, cur;

    initial begin
        //          ov    de    act   hs    vs    game        go          exp
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hAABBCC, 24'h000000, 24'hAABBCC};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h123456, 24'h000000, 24'h102030};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 24'h000000, 24'h000000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFF8040, 24'hFF0000, 24'hFF0000};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFF8040, 24'h000000, 24'h3F2010};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h777777, 24'h000000, 24'h04080C};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'hFF8040, 24'hFF0000, 24'h000000};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 24'h000001, 24'h000001};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, 24'hFF0000, 24'h000000};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0307FC, 24'h000000, 24'h00013F};

        // Reset with busy inputs: everything must read 0
        rst = 1'b1; fsync = 1'b1; use_gameover_pixels = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        set_pix(1'b1, 1'b1, 24'hFFFFFF, 24'hFF0000);
        repeat (3) tick();
        chk("reset_pixel", pixel_out, 24'h0);
        chk("reset_de", 24'(de_out), 24'h0);
        chk("reset_hs", 24'(hsync_out), 24'h0);
        chk("reset_vs", 24'(vsync_out), 24'h0);
        chk("reset_overlay", 24'(overlay_active), 24'h0);

        // Latency after reset release: exactly 2 edges
        rst = 1'b0; fsync = 1'b0; use_gameover_pixels = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b0;
        set_pix(1'b1, 1'b1, 24'h102030, 24'h000000);
        tick();
        chk("lat1_pixel", pixel_out, 24'h0);
        chk("lat1_hs", 24'(hsync_out), 24'h0);
        chk("lat1_de", 24'(de_out), 24'h0);
        tick();
        chk("lat2_pixel", pixel_out, 24'h102030);
        chk("lat2_hs", 24'(hsync_out), 24'h1);
        chk("lat2_vs", 24'(vsync_out), 24'h0);
        chk("lat2_de", 24'(de_out), 24'h1);

        // Timing pass-through with a varying pattern
        prev = {1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            cur = 3'($urandom_range(0, 7));
            {hsync_in, vsync_in, de_in} = cur;
            tick();
            chk("sync_hs", 24'(hsync_out), 24'(prev[2]));
            chk("sync_vs", 24'(vsync_out), 24'(prev[1]));
            chk("sync_de", 24'(de_out), 24'(prev[0]));
            chk("sync_pixel", pixel_out, prev[0] ? 24'h102030 : 24'h0);
            prev = cur;
        end

        // Table vectors: clear overlay, then load the vector's overlay on fsync
        for (int v = 0; v < 10; v++) begin
            fsync = 1'b1; use_gameover_pixels = 1'b0;
            tick();
            use_gameover_pixels = vecs[v].ov;
            hsync_in = vecs[v].hs; vsync_in = vecs[v].vs;
            set_pix(vecs[v].de, vecs[v].act, vecs[v].game, vecs[v].go);
            tick();
            fsync = 1'b0;
            tick();
            chk($sformatf("vec%0d_pixel", v), pixel_out, vecs[v].exp);
            chk($sformatf("vec%0d_overlay", v), 24'(overlay_active), 24'(vecs[v].ov));
            chk($sformatf("vec%0d_hs", v), 24'(hsync_out), 24'(vecs[v].hs));
            chk($sformatf("vec%0d_vs", v), 24'(vsync_out), 24'(vecs[v].vs));
            chk($sformatf("vec%0d_de", v), 24'(de_out), 24'(vecs[v].de));
        end

        // Mid-frame request is ignored until the next fsync
        hsync_in = 1'b0; vsync_in = 1'b0;
        set_pix(1'b1, 1'b1, 24'hFF8040, 24'hFF0000);
        fsync = 1'b1; use_gameover_pixels = 1'b0;
        tick();
        fsync = 1'b0; use_gameover_pixels = 1'b1;
        repeat (3) tick();
        chk("mid_req_overlay", 24'(overlay_active), 24'h0);
        chk("mid_req_pixel", pixel_out, 24'hFF8040);
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        chk("fsync_load_overlay", 24'(overlay_active), 24'h1);
        tick();
        chk("fsync_load_pixel", pixel_out, 24'hFF0000);
        use_gameover_pixels = 1'b0;
        repeat (2) tick();
        chk("mid_drop_overlay", 24'(overlay_active), 24'h1);
        chk("mid_drop_pixel", pixel_out, 24'hFF0000);

        // Mid-frame reset with overlay on
        use_gameover_pixels = 1'b1; hsync_in = 1'b1;
        rst = 1'b1;
        tick();
        chk("mrst_pixel", pixel_out, 24'h0);
        chk("mrst_de", 24'(de_out), 24'h0);
        chk("mrst_hs", 24'(hsync_out), 24'h0);
        chk("mrst_overlay", 24'(overlay_active), 24'h0);
        rst = 1'b0;
        tick();
        chk("mrst_hold_pixel", pixel_out, 24'h0);
        chk("mrst_hold_de", 24'(de_out), 24'h0);
        tick();
        chk("mrst_base_pixel", pixel_out, 24'hFF8040);
        repeat (2) tick();
        chk("mrst_wait_overlay", 24'(overlay_active), 24'h0);
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        chk("mrst_resume_overlay", 24'(overlay_active), 24'h1);
        tick();
        chk("mrst_resume_pixel", pixel_out, 24'hFF0000);

        // Blink sequence: with BLINK_FRAMES=2, frames 3-4 are dimmed-only
        frame(1'b0, 4);
        for (int f = 1; f <= 6; f++) begin
            frame(1'b1, 4);
            chk($sformatf("blink_f%0d", f), pixel_out,
                (BLINK && (f == 3 || f == 4)) ? 24'h3F2010 : 24'hFF0000);
        end
        frame(1'b0, 4);
        chk("blink_drop", pixel_out, 24'hFF8040);
        frame(1'b1, 4);
        chk("blink_reraise", pixel_out, 24'hFF0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_compositor.md
FRAME_COMPOSITOR -- requirements
Module: frame_compositor

Interface
REQ-001 Parameter: BG_COLOR, 24'h000000, RGB drawn where no layer is active.
REQ-002 Parameter: BLINK_FRAMES, 16, frames per game-over blink half-period; range 1..255.
REQ-003 pixel_clk  in  1  pixel clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 fsync  in  1  one-cycle pulse at frame start.
REQ-006 hsync_in, vsync_in, de_in  in  1 each  raw timing from the VGA timing generator.
REQ-007 pixel_game  in  8 x3 ([0]=B,[1]=G,[2]=R)  composited ball/paddle/score layer.
REQ-008 active_game  in  1  pixel_game is valid for this pixel.
REQ-009 use_gameover_pixels  in  1  game-over overlay requested.
REQ-010 pixel_gameover  in  8 x3  game-over bitmap RGB; all-zero means transparent.
REQ-011 hsync_out, vsync_out, de_out  out  1 each  timing delayed to match pixel_out.
REQ-012 pixel_out  out  8 x3  final RGB to the video output.
REQ-013 overlay_active  out  1  frame-stable overlay flag, for the score/lives logic.

Function
REQ-014 Latency SHALL be exactly 2 cycles from any input to pixel_out; hsync/vsync/de SHALL pass through an equal 2-stage delay.
REQ-015 Stage 1 SHALL register de_in, active_game, pixel_game, pixel_gameover and the transparency test (all three gameover channels zero).
REQ-016 Stage 2 SHALL register the selected colour into pixel_out.
REQ-017 overlay_active SHALL load use_gameover_pixels only on cycles with fsync=1 and hold it for the rest of the frame; mid-frame changes of use_gameover_pixels SHALL be ignored.
REQ-018 When fsync and a change of use_gameover_pixels coincide, the new value SHALL be loaded.
REQ-019 Select, priority order: delayed de=0 -> 0; overlay_active=1 and text visible and gameover non-transparent -> pixel_gameover; overlay_active=1 otherwise -> dimmed base; overlay_active=0 -> base.
REQ-020 Base colour SHALL be pixel_game when active_game=1, else BG_COLOR.
REQ-021 Dimming SHALL be a per-channel logical shift right by 2 (8'hFF -> 8'h3F), with no carry between channels.
REQ-022 Text is visible whenever GAMEOVER_BLINK_EN is undefined.
REQ-023 The overlay_active used in the select SHALL be the value at stage-2 time, so a pixel is never split between modes.

Reset
REQ-024 With rst=1 at a clock edge, all pipeline registers, hsync_out, vsync_out, de_out, pixel_out, overlay_active, the blink counter and the blink phase SHALL clear to 0 on that edge.
REQ-025 After a mid-frame reset, outputs SHALL stay at 0 for 2 cycles, and overlay_active SHALL stay 0 until the next fsync.

Configuration
REQ-026 The macro GAMEOVER_BLINK_EN SHALL compile in a blink feature: an 8-bit frame counter and a phase bit (phase 0 = text visible).
REQ-027 With the macro defined, while overlay_active=1, each fsync SHALL increment the counter.
REQ-028 With the macro defined, on the fsync where the counter equals BLINK_FRAMES-1, the counter SHALL wrap to 0 and the phase SHALL toggle.
REQ-029 With the macro defined, when overlay_active=0, the counter and phase SHALL be held at 0, so each overlay starts in the visible phase.
REQ-030 With the macro undefined, no counter or phase registers SHALL exist, and the text SHALL be always visible.

Verification
REQ-031 Reset release, de_in=1, active_game=1, pixel_game={8'h10,8'h20,8'h30}, no overlay -> pixel_out={10,20,30} exactly 2 cycles later; hsync/vsync/de_out equal to the inputs delayed 2 cycles.
REQ-032 active_game=0, BG_COLOR=24'h102030 -> pixel_out R=10 G=20 B=30; de_in=0 -> pixel_out=0.
REQ-033 use_gameover_pixels rises mid-frame -> overlay_active stays 0 until the next fsync, then goes 1; gameover={FF,00,00} -> pixel_out={FF,00,00}; transparent pixel over game {FF,80,40} -> {3F,20,10}.
REQ-034 Blink build, BLINK_FRAMES=2 -> text visible frames 1-2, dimmed-only frames 3-4, visible frames 5-6; overlay drop then re-raise -> first overlay frame visible.
REQ-035 Assert rst mid-frame with overlay on -> all outputs 0 on the next edge; overlay resumes only after the next fsync with use_gameover_pixels=1.
